// File: rtl/pkt_framer.sv
// Frame generator: queues frame-length requests and emits head/data/tail bursts
// with a forced idle gap after each tail. Tracks completed frames and bad lengths.
module pkt_framer #(
    parameter int LEN_W   = 8,
    parameter int QDEPTH  = 2,
    parameter int MIN_GAP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    output logic             head,
    output logic             tail,
    output logic             valid,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic             err_len
);

    localparam int AW    = $clog2(QDEPTH);
    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(QDEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = (MIN_GAP > 0) ? GAP_W'(MIN_GAP - 1) : '0;
    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(2);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HEAD = 3'd1,
        S_DATA = 3'd2,
        S_TAIL = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [GAP_W-1:0] gap, gap_n;

    logic [LEN_W-1:0] mem [QDEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fifo_cnt;
    logic             fifo_empty, fifo_full;
    logic             accept, push, pop;
    logic [LEN_W-1:0] q_len;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    assign req_ready  = !fifo_full;
    assign accept     = req_valid && req_ready;
    assign push       = accept && (req_len >= MIN_LEN);
    assign q_len      = mem[rd_ptr];

    // Storage carries no reset; occupancy is tracked by fifo_cnt alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= req_len;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop)
                fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            gap         <= '0;
            frame_count <= '0;
            err_len     <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            gap     <= gap_n;
            err_len <= accept && (req_len < MIN_LEN);
            if (state == S_TAIL)
                frame_count <= frame_count + 16'd1;
        end
    end

    // Beat counter holds the number of DATA beats still to emit.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gap_n   = gap;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cnt_n   = q_len - MIN_LEN;
                    state_n = S_HEAD;
                end
            end
            S_HEAD: begin
                state_n = (cnt == '0) ? S_TAIL : S_DATA;
            end
            S_DATA: begin
                cnt_n = cnt - 1'b1;
                if (cnt == LEN_W'(1))
                    state_n = S_TAIL;
            end
            S_TAIL: begin
                if (MIN_GAP > 0) begin
                    gap_n   = GAP_LOAD;
                    state_n = S_GAP;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    cnt_n   = q_len - MIN_LEN;
                    state_n = S_HEAD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap != '0) begin
                    gap_n = gap - 1'b1;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    cnt_n   = q_len - MIN_LEN;
                    state_n = S_HEAD;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign head  = (state == S_HEAD);
    assign tail  = (state == S_TAIL);
    assign valid = (state == S_HEAD) || (state == S_DATA) || (state == S_TAIL);
    assign busy  = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_pkt_framer.sv
// Directed bench for pkt_framer (QDEPTH=2, MIN_GAP=1); beats are encoded as
// {valid,head,tail}: idle '_'=000, head 'H'=110, data 'D'=100, tail 'T'=101.
module tb_pkt_framer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [7:0] req_len;
    logic       req_ready, head, tail, valid, busy, err_len;
    logic [15:0] frame_count;

    int n_chk  = 0;
    int n_pass = 0;

    pkt_framer #(.LEN_W(8), .QDEPTH(2), .MIN_GAP(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_len     (req_len),
        .req_ready   (req_ready),
        .head        (head),
        .tail        (tail),
        .valid       (valid),
        .busy        (busy),
        .frame_count (frame_count),
        .err_len     (err_len)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [2:0] beat();
        return {valid, head, tail};
    endfunction

    function automatic logic [2:0] code(input byte c);
        case (c)
            "H":     return 3'b110;
            "D":     return 3'b100;
            "T":     return 3'b101;
            default: return 3'b000;
        endcase
    endfunction

    // Compare the current beat against pat[0], step, compare pat[1], ...
    task automatic expect_beats(input string tag, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), 32'(beat()), 32'(code(pat[i])));
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_len   = '0;
        repeat (3) step();

        // reset state
        chk("rst_beat",  32'(beat()), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_err",   32'(err_len), 32'd0);
        chk("rst_fc",    32'(frame_count), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;

        // single minimum-length frame
        req_valid = 1'b1; req_len = 8'd2;
        step();
        req_valid = 1'b0;
        chk("f2_busy", 32'(busy), 32'd1);
        expect_beats("f2", "_HT_");
        chk("f2_fc",   32'(frame_count), 32'd1);
        chk("f2_idle", 32'(busy), 32'd0);

        // back-to-back requests 5 then 3; length change after push is ignored
        req_valid = 1'b1; req_len = 8'd5;
        step();
        req_len = 8'd3;
        step();
        req_valid = 1'b0; req_len = 8'd0;
        expect_beats("f53", "HDDDT_HDT_");
        chk("f53_fc",   32'(frame_count), 32'd3);
        chk("f53_idle", 32'(busy), 32'd0);

        // fill FIFO while a len=4 frame runs; 4th request waits for a pop
        req_valid = 1'b1; req_len = 8'd4;
        step();
        req_valid = 1'b0;
        chk("fq_a0", 32'(beat()), 32'(code("_")));
        step();
        chk("fq_a1", 32'(beat()), 32'(code("H")));
        req_valid = 1'b1; req_len = 8'd3;
        step();
        chk("fq_a2", 32'(beat()), 32'(code("D")));
        req_len = 8'd2;
        step();
        req_len = 8'd5;
        chk("fq_full", 32'(req_ready), 32'd0);
        expect_beats("fq1", "DT_H");
        req_valid = 1'b0;
        chk("fq_full2", 32'(req_ready), 32'd0);
        expect_beats("fq2", "DT_HT_HDDDT__");
        chk("fq_fc",   32'(frame_count), 32'd7);
        chk("fq_idle", 32'(busy), 32'd0);

        // illegal lengths
        req_valid = 1'b1; req_len = 8'd1;
        step();
        req_valid = 1'b0;
        chk("e1_err", 32'(err_len), 32'd1);
        step();
        chk("e1_clr", 32'(err_len), 32'd0);
        req_valid = 1'b1; req_len = 8'd0;
        step();
        req_valid = 1'b0;
        chk("e0_err", 32'(err_len), 32'd1);
        step();
        chk("e0_clr",  32'(err_len), 32'd0);
        chk("e_beat",  32'(beat()), 32'd0);
        chk("e_busy",  32'(busy), 32'd0);
        chk("e_fc",    32'(frame_count), 32'd7);

        // reset during DATA with another request queued
        req_valid = 1'b1; req_len = 8'd10;
        step();
        req_len = 8'd3;
        step();
        req_valid = 1'b0;
        chk("r_head", 32'(beat()), 32'(code("H")));
        step();
        chk("r_data", 32'(beat()), 32'(code("D")));
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("r_beat",  32'(beat()), 32'd0);
        chk("r_busy",  32'(busy), 32'd0);
        chk("r_fc",    32'(frame_count), 32'd0);
        chk("r_ready", 32'(req_ready), 32'd1);
        expect_beats("r_after", "___");
        chk("r_busy2", 32'(busy), 32'd0);
        chk("r_fc2",   32'(frame_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
